// File: rtl/ahb_apb_bridge_mp.sv
// ahb_apb_bridge_mp: AHB-lite slave to multi-slave APB bridge with error response and access timeout
module ahb_apb_bridge_mp #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_SEL_LSB    = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic                             HSEL,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  input  logic                             HWRITE,
  input  logic [DATA_WIDTH-1:0]            HWDATA,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic [1:0]                       HRESP,
  output logic                             HREADY_OUT,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);
  localparam int SW  = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam int NS2 = 1 << SW;
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 2);
  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;
  state_t                    r_state;
  logic [SW-1:0]             r_idx;
  logic [CW-1:0]             r_cnt;
  logic [DATA_WIDTH-1:0]     r_hrdata;
  logic [1:0]                r_hresp;
  logic                      r_hready;
  logic [NUM_SLAVES-1:0]     r_psel;
  logic                      r_penable;
  logic [ADDR_WIDTH-1:0]     r_paddr;
  logic                      r_pwrite;
  logic [DATA_WIDTH-1:0]     r_pwdata;
  logic [SW-1:0]             w_idx;
  logic                      w_start, w_bad, w_rdy, w_err, w_tmo;
  logic [NS2-1:0]            w_prdy, w_perr, w_oh_new, w_oh_cur;
  logic [NS2*DATA_WIDTH-1:0] w_prdata;
  logic [DATA_WIDTH-1:0]     w_rd;
  // Slave-side inputs are zero-padded to a power of two so any index value selects safely
  assign w_idx    = HADDR[SLV_SEL_LSB +: SW];
  assign w_start  = HSEL && HTRANS[1];
  assign w_bad    = 32'(w_idx) >= NUM_SLAVES;
  assign w_prdy   = NS2'(PREADY);
  assign w_perr   = NS2'(PSLVERR);
  assign w_prdata = (NS2 * DATA_WIDTH)'(PRDATA);
  assign w_rdy    = w_prdy[r_idx];
  assign w_err    = w_perr[r_idx];
  assign w_rd     = w_prdata[32'(r_idx) * DATA_WIDTH +: DATA_WIDTH];
  assign w_oh_new = NS2'(1) << w_idx;
  assign w_oh_cur = NS2'(1) << r_idx;
  assign w_tmo    = (TIMEOUT_CYCLES != 0) && (r_cnt + 1'b1 == CW'(TIMEOUT_CYCLES));
  assign HRDATA     = r_hrdata;
  assign HRESP      = r_hresp;
  assign HREADY_OUT = r_hready;
  assign PSEL       = r_psel;
  assign PENABLE    = r_penable;
  assign PADDR      = r_paddr;
  assign PWRITE     = r_pwrite;
  assign PWDATA     = r_pwdata;
  // Bridge FSM with all AHB and APB outputs registered alongside the state
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_hrdata  <= '0;
      r_hresp   <= 2'b00;
      r_hready  <= 1'b1;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_paddr  <= HADDR;
          r_pwrite <= HWRITE;
          r_idx    <= w_idx;
          r_hready <= 1'b0;
          if (w_bad) begin
            r_state <= ERR1;
            r_hresp <= 2'b01;
          end else if (HWRITE) begin
            r_state <= WDATA;
          end else begin
            r_state <= SETUP;
            r_psel  <= w_oh_new[NUM_SLAVES-1:0];
          end
        end
        WDATA: begin
          r_pwdata <= HWDATA;
          r_state  <= SETUP;
          r_psel   <= w_oh_cur[NUM_SLAVES-1:0];
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
          r_cnt     <= '0;
        end
        ACCESS: if (w_rdy || w_tmo) begin
          r_psel    <= '0;
          r_penable <= 1'b0;
          if (w_rdy && !w_err) begin
            r_state  <= IDLE;
            r_hready <= 1'b1;
            if (!r_pwrite) r_hrdata <= w_rd;
          end else begin
            r_state <= ERR1;
            r_hresp <= 2'b01;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        ERR1: begin
          r_state  <= ERR2;
          r_hready <= 1'b1;
        end
        ERR2: begin
          r_state <= IDLE;
          r_hresp <= 2'b00;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_apb_bridge_mp.sv
// tb_ahb_apb_bridge_mp: directed checks of the AHB-to-APB bridge
module tb_ahb_apb_bridge_mp;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         hsel = 1'b0, hsel2 = 1'b0;
  logic [31:0]  haddr = '0;
  logic [1:0]   htrans = '0;
  logic         hwrite = 1'b0;
  logic [31:0]  hwdata = '0;
  logic [127:0] prdata = '0;
  logic [3:0]   pready = '0, pslverr = '0;
  logic [31:0]  hrdata, paddr, pwdata, hrdata2, paddr2, pwdata2;
  logic [1:0]   hresp, hresp2;
  logic         hready, penable, pwrite, hready2, penable2, pwrite2;
  logic [3:0]   psel;
  logic [2:0]   psel2;
  int           errors = 0, checks = 0;

  always #5 clk = ~clk;

  ahb_apb_bridge_mp #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(4)) u_dut (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HWDATA(hwdata), .HRDATA(hrdata), .HRESP(hresp), .HREADY_OUT(hready), .PSEL(psel),
    .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata),
    .PREADY(pready), .PSLVERR(pslverr));

  ahb_apb_bridge_mp #(.NUM_SLAVES(3), .TIMEOUT_CYCLES(4)) u_dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HWDATA(hwdata), .HRDATA(hrdata2), .HRESP(hresp2), .HREADY_OUT(hready2), .PSEL(psel2),
    .PENABLE(penable2), .PADDR(paddr2), .PWRITE(pwrite2), .PWDATA(pwdata2), .PRDATA(prdata[95:0]),
    .PREADY(pready[2:0]), .PSLVERR(pslverr[2:0]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    hsel = 1'b0; hsel2 = 1'b0; htrans = 2'b00;
  endtask

  initial begin
    step(); step();
    chk("rst_hready", hready, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_pwdata", pwdata, 0);
    rst = 1'b0;
    // write to slave 1, other slaves signal errors that must be ignored
    hsel = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h0000_1004;
    pready = 4'b1111; pslverr = 4'b1101;
    step();
    chk("wr_wdata_hready", hready, 0);
    chk("wr_wdata_psel", psel, 0);
    idle_bus(); hwdata = 32'hDEAD_BEEF;
    step();
    chk("wr_setup_psel", psel, 4'b0010);
    chk("wr_setup_penable", penable, 0);
    chk("wr_setup_paddr", paddr, 32'h1004);
    chk("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("wr_setup_pwrite", pwrite, 1);
    chk("wr_setup_hready", hready, 0);
    hwdata = 32'h0;
    step();
    chk("wr_access_penable", penable, 1);
    chk("wr_access_psel", psel, 4'b0010);
    chk("wr_access_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("wr_access_hready", hready, 0);
    step();
    chk("wr_done_hready", hready, 1);
    chk("wr_done_hresp", hresp, 0);
    chk("wr_done_psel", psel, 0);
    chk("wr_done_penable", penable, 0);
    chk("wr_done_hrdata", hrdata, 0);
    // read slave 3 with two wait states
    prdata[3*32 +: 32] = 32'h1234_5678; prdata[0 +: 32] = 32'hAAAA_AAAA;
    pready = 4'b0111; pslverr = 4'b0000;
    hsel = 1; htrans = 2'b10; hwrite = 0; haddr = 32'h0000_3000;
    step();
    idle_bus();
    chk("rd_setup_psel", psel, 4'b1000);
    chk("rd_setup_penable", penable, 0);
    chk("rd_setup_pwrite", pwrite, 0);
    step();
    chk("rd_acc1_penable", penable, 1);
    step();
    chk("rd_acc2_penable", penable, 1);
    step();
    chk("rd_acc3_penable", penable, 1);
    chk("rd_acc3_hready", hready, 0);
    pready = 4'b1000;
    step();
    chk("rd_done_hrdata", hrdata, 32'h1234_5678);
    chk("rd_done_hresp", hresp, 0);
    chk("rd_done_hready", hready, 1);
    chk("rd_done_penable", penable, 0);
    // read slave 2 with slave error
    prdata[2*32 +: 32] = 32'h5555_AAAA; pready = 4'b1111; pslverr = 4'b0100;
    hsel = 1; htrans = 2'b10; hwrite = 0; haddr = 32'h0000_2000;
    step();
    idle_bus();
    chk("err_setup_psel", psel, 4'b0100);
    step();
    step();
    chk("err1_hresp", hresp, 2'b01);
    chk("err1_hready", hready, 0);
    chk("err1_psel", psel, 0);
    chk("err1_penable", penable, 0);
    hsel = 1; htrans = 2'b10; haddr = 32'h0000_0000;
    step();
    chk("err2_hresp", hresp, 2'b01);
    chk("err2_hready", hready, 1);
    step();
    idle_bus();
    chk("err_idle_hresp", hresp, 0);
    chk("err_idle_hready", hready, 1);
    chk("err_ignored_psel", psel, 0);
    chk("err_hrdata_kept", hrdata, 32'h1234_5678);
    // timeout on slave 0
    pready = 4'b0000; pslverr = 4'b0000;
    hsel = 1; htrans = 2'b10; hwrite = 0; haddr = 32'h0000_0000;
    step();
    idle_bus();
    chk("to_setup_psel", psel, 4'b0001);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("to_acc%0d_penable", i), penable, 1);
    end
    step();
    chk("to_err1_hresp", hresp, 2'b01);
    chk("to_err1_penable", penable, 0);
    chk("to_err1_psel", psel, 0);
    chk("to_err1_hready", hready, 0);
    step();
    chk("to_err2_hready", hready, 1);
    chk("to_err2_hresp", hresp, 2'b01);
    step();
    chk("to_idle_hresp", hresp, 0);
    chk("to_idle_hready", hready, 1);
    // out-of-range slave on the 3-slave bridge
    hsel2 = 1; htrans = 2'b10; hwrite = 0; haddr = 32'h0000_3000;
    step();
    idle_bus();
    chk("oor_err1_psel", psel2, 0);
    chk("oor_err1_hresp", hresp2, 2'b01);
    chk("oor_err1_hready", hready2, 0);
    chk("oor_err1_penable", penable2, 0);
    step();
    chk("oor_err2_psel", psel2, 0);
    chk("oor_err2_hresp", hresp2, 2'b01);
    chk("oor_err2_hready", hready2, 1);
    step();
    chk("oor_idle_hresp", hresp2, 0);
    // reset pulse during ACCESS
    hsel = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h0000_1008; pready = 4'b0000;
    step();
    idle_bus(); hwdata = 32'h0BAD_F00D;
    step();
    step();
    chk("rst_mid_penable_before", penable, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_psel", psel, 0);
    chk("rst_mid_penable", penable, 0);
    chk("rst_mid_paddr", paddr, 0);
    chk("rst_mid_pwdata", pwdata, 0);
    chk("rst_mid_hready", hready, 1);
    chk("rst_mid_hrdata", hrdata, 0);
    #1 rst = 1'b0;
    prdata[1*32 +: 32] = 32'hCAFE_0001; pready = 4'b0010; pslverr = 4'b0000;
    hsel = 1; htrans = 2'b10; hwrite = 0; haddr = 32'h0000_1000;
    step();
    idle_bus();
    chk("post_rst_setup_psel", psel, 4'b0010);
    chk("post_rst_paddr", paddr, 32'h1000);
    step();
    chk("post_rst_access_penable", penable, 1);
    step();
    chk("post_rst_hrdata", hrdata, 32'hCAFE_0001);
    chk("post_rst_hresp", hresp, 0);
    chk("post_rst_hready", hready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
